// File: rtl/result_drain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : result_drain
//  Description : Readback stage for the PE array. On a drain_start pulse it
//                walks every PE (0..SIZE*SIZE-1) and, inside each PE, the
//                register window BASE_ADDR..BASE_ADDR+NUM_REGS-1 through the
//                array's PE_Addr/RegAddr/data readout port. Each word is
//                presented on a valid/ready stream. A done pulse follows the
//                final handshake.
//
//  Ports       : clk          - system clock, rising edge
//                reset        - synchronous, active-high
//                drain_start  - one-cycle pulse, starts a drain when idle
//                pe_addr      - PE select toward the array (SIZE bits)
//                reg_addr     - register select toward the array (10 bits)
//                rd_data      - array readout data (16 bits)
//                out_data     - stream payload (16 bits)
//                out_valid    - payload valid
//                out_ready    - consumer ready
//                out_last     - marks the final word of a drain
//                busy         - drain in progress
//                done         - one-cycle completion pulse
//
//  Options     : DRAIN_CHECKSUM_EN - when defined, a 16-bit XOR of all data
//                words is appended as one extra word, which then carries
//                out_last.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module result_drain #(
    parameter int SIZE      = 4,
    parameter int NUM_REGS  = 16,
    parameter int BASE_ADDR = 0,
    parameter int READ_LAT  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            drain_start,
    output logic [SIZE-1:0] pe_addr,
    output logic [9:0]      reg_addr,
    input  logic [15:0]     rd_data,
    output logic [15:0]     out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic            busy,
    output logic            done
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if ((NUM_REGS < 1) || (NUM_REGS > 1024)) begin : g_bad_num_regs
            $error("result_drain: NUM_REGS must be in 1..1024");
        end
        if ((BASE_ADDR < 0) || ((BASE_ADDR + NUM_REGS - 1) > 1023)) begin : g_bad_base_addr
            $error("result_drain: BASE_ADDR+NUM_REGS-1 must not exceed 1023");
        end
        if ((READ_LAT < 0) || (READ_LAT > 3)) begin : g_bad_read_lat
            $error("result_drain: READ_LAT must be in 0..3");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [SIZE-1:0] c_PE_LAST   = SIZE'(SIZE * SIZE - 1);
    localparam logic [9:0]      c_REG_LAST  = 10'(NUM_REGS - 1);
    localparam logic [9:0]      c_BASE      = 10'(BASE_ADDR);
    // WAIT counts down from READ_LAT-1 to 0; capture happens on the 0 cycle.
    localparam logic [1:0]      c_WAIT_INIT = 2'((READ_LAT > 0) ? (READ_LAT - 1) : 0);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_ISSUE = 3'd1;
    localparam logic [2:0] c_S_WAIT  = 3'd2;
    localparam logic [2:0] c_S_HOLD  = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    logic [2:0]      r_state;
    logic [SIZE-1:0] r_pe;
    logic [9:0]      r_reg;
    logic [1:0]      r_wait;
    logic [SIZE-1:0] r_pe_addr;
    logic [9:0]      r_reg_addr;
    logic [15:0]     r_out_data;
    logic            r_out_valid;
    logic            r_out_last;
    logic            r_busy;
    logic            r_done;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic            w_start;
    logic            w_capture;
    logic            w_last_data;
    logic            w_final;
    logic            w_csum_turn;
    logic [15:0]     w_cap_data;
    logic            w_cap_last;
    logic            w_reg_wrap;
    logic [9:0]      w_next_reg;
    logic [SIZE-1:0] w_next_pe;

    assign w_start     = (r_state == c_S_IDLE) && drain_start;
    // Readout data is sampled at the end of ISSUE when there is no read
    // latency, otherwise at the end of the last WAIT cycle.
    assign w_capture   = ((r_state == c_S_ISSUE) && (READ_LAT == 0)) ||
                         ((r_state == c_S_WAIT)  && (r_wait == 2'd0));
    assign w_last_data = (r_pe == c_PE_LAST) && (r_reg == c_REG_LAST);

    // PE-major walk: registers advance fastest, PE steps on register wrap.
    assign w_reg_wrap  = (r_reg == c_REG_LAST);
    assign w_next_reg  = w_reg_wrap ? 10'd0 : (r_reg + 10'd1);
    assign w_next_pe   = w_reg_wrap ? (r_pe + 1'b1) : r_pe;

`ifdef DRAIN_CHECKSUM_EN
    // ------------------------------------------------------------------------
    // Running XOR of captured data words. After the final data word is
    // accepted, the FSM makes one more ISSUE/WAIT/HOLD pass with the address
    // counters frozen; that pass captures the checksum instead of rd_data.
    // ------------------------------------------------------------------------
    logic [15:0] r_csum;
    logic        r_csum_phase;

    assign w_csum_turn = (r_state == c_S_HOLD) && out_ready && w_last_data && !r_csum_phase;
    assign w_final     = r_csum_phase;

    always_comb begin
        w_cap_data = rd_data;
        w_cap_last = 1'b0;
        if (r_csum_phase) begin
            w_cap_data = r_csum;
            w_cap_last = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_csum       <= 16'd0;
            r_csum_phase <= 1'b0;
        end else begin
            if (w_start) begin
                r_csum <= 16'd0;
            end else if (w_capture && !r_csum_phase) begin
                r_csum <= r_csum ^ rd_data;
            end

            if (w_start) begin
                r_csum_phase <= 1'b0;
            end else if (w_csum_turn) begin
                r_csum_phase <= 1'b1;
            end else if (r_state == c_S_DONE) begin
                r_csum_phase <= 1'b0;
            end
        end
    end
`else
    assign w_csum_turn = 1'b0;
    assign w_final     = w_last_data;

    always_comb begin
        w_cap_data = rd_data;
        w_cap_last = w_last_data;
    end
`endif

    // ------------------------------------------------------------------------
    // Main FSM. All outputs are registered here so the array address and the
    // stream signals never glitch.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_S_IDLE;
            r_pe        <= '0;
            r_reg       <= 10'd0;
            r_wait      <= 2'd0;
            r_pe_addr   <= '0;
            r_reg_addr  <= c_BASE;
            r_out_data  <= 16'd0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    r_done <= 1'b0;
                    if (drain_start) begin
                        r_state    <= c_S_ISSUE;
                        r_pe       <= '0;
                        r_reg      <= 10'd0;
                        r_pe_addr  <= '0;
                        r_reg_addr <= c_BASE;
                        r_busy     <= 1'b1;
                    end
                end

                c_S_ISSUE: begin
                    // Address registers already hold the counters; the array
                    // sees them from the first ISSUE cycle onward.
                    if (READ_LAT == 0) begin
                        r_out_data  <= w_cap_data;
                        r_out_last  <= w_cap_last;
                        r_out_valid <= 1'b1;
                        r_state     <= c_S_HOLD;
                    end else begin
                        r_wait  <= c_WAIT_INIT;
                        r_state <= c_S_WAIT;
                    end
                end

                c_S_WAIT: begin
                    if (r_wait == 2'd0) begin
                        r_out_data  <= w_cap_data;
                        r_out_last  <= w_cap_last;
                        r_out_valid <= 1'b1;
                        r_state     <= c_S_HOLD;
                    end else begin
                        r_wait <= r_wait - 2'd1;
                    end
                end

                c_S_HOLD: begin
                    // Payload, last flag and addresses stay frozen until the
                    // consumer accepts the word.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (w_final) begin
                            r_state <= c_S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else if (w_csum_turn) begin
                            r_state <= c_S_ISSUE;
                        end else begin
                            r_reg      <= w_next_reg;
                            r_pe       <= w_next_pe;
                            r_reg_addr <= c_BASE + w_next_reg;
                            r_pe_addr  <= w_next_pe;
                            r_state    <= c_S_ISSUE;
                        end
                    end
                end

                c_S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= c_S_IDLE;
                end

                default: begin
                    r_state     <= c_S_IDLE;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign pe_addr   = r_pe_addr;
    assign reg_addr  = r_reg_addr;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_result_drain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_result_drain
//  Description : Self-checking bench for result_drain. A registered memory
//                model returns {pe, reg[7:0]} one cycle after the address.
//                A short control table covers reset/start/handshake edges,
//                then full drains are checked against a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_result_drain;

    localparam int SIZE      = 4;
    localparam int NUM_REGS  = 16;
    localparam int BASE_ADDR = 0;
    localparam int READ_LAT  = 1;
    localparam int WORDS     = SIZE * SIZE * NUM_REGS;
`ifdef DRAIN_CHECKSUM_EN
    localparam int TOTAL     = WORDS + 1;
`else
    localparam int TOTAL     = WORDS;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        drain_start;
    logic [3:0]  pe_addr;
    logic [9:0]  reg_addr;
    logic [15:0] rd_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    result_drain #(
        .SIZE      (SIZE),
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR),
        .READ_LAT  (READ_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .drain_start (drain_start),
        .pe_addr     (pe_addr),
        .reg_addr    (reg_addr),
        .rd_data     (rd_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Array readout model: one cycle of latency, word = pe*256 + reg.
    always @(posedge clk) rd_data <= {4'h0, pe_addr, reg_addr[7:0]};

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic [3:0]  pe;
        logic [9:0]  ra;
    } exp_t;

    // {busy, valid, done, last, pe[3:0], reg_addr[9:0], data[15:0]}
    typedef struct packed {
        logic        rst;
        logic        start;
        logic        rdy;
        logic [33:0] exp;
    } vec_t;

    exp_t q[$];
    vec_t tbl [13];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [33:0] pk(input logic b, input logic v, input logic d,
                                       input logic l, input logic [3:0] p,
                                       input logic [9:0] r, input logic [15:0] x);
        return {b, v, d, l, p, r, x};
    endfunction

    function automatic logic [33:0] outs();
        return {busy, out_valid, done, out_last, pe_addr, reg_addr, out_data};
    endfunction

    task automatic push_drain();
        logic [15:0] x;
        exp_t        e;
        x = 16'h0;
        for (int p = 0; p < SIZE * SIZE; p++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                e.data = {4'h0, 4'(p), 8'(r)};
                e.pe   = 4'(p);
                e.ra   = 10'(BASE_ADDR + r);
`ifdef DRAIN_CHECKSUM_EN
                e.last = 1'b0;
`else
                e.last = (p == SIZE * SIZE - 1) && (r == NUM_REGS - 1);
`endif
                x = x ^ e.data;
                q.push_back(e);
            end
        end
`ifdef DRAIN_CHECKSUM_EN
        e.data = x;
        e.last = 1'b1;
        e.pe   = 4'(SIZE * SIZE - 1);
        e.ra   = 10'(BASE_ADDR + NUM_REGS - 1);
        q.push_back(e);
`endif
    endtask

    // Runs one drain. Entered and left at posedge+1. Negative arguments
    // disable the corresponding corner case.
    task automatic run_drain(input int stall_at, input int ign_a, input int ign_b,
                             input int reset_at, input bit gap_chk);
        int   hs         = 0;
        int   last_hs    = -1;
        int   done_cnt   = 0;
        int   done_iter  = -1;
        int   stall_left = 5;
        bit   finished   = 1'b0;
        exp_t e;

        drain_start = 1'b1;
        out_ready   = 1'b1;
        push_drain();
        @(posedge clk); #1;

        for (int iter = 1; iter < 3000; iter++) begin
            drain_start = 1'b0;
            out_ready   = 1'b1;

            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_iter = iter;
                    chk("done_after_last", 64'(iter), 64'(last_hs + 1));
                    chk("busy_in_done", {63'd0, busy}, 64'd0);
                end
            end

            if (reset_at >= 0 && out_valid && hs == reset_at) begin
                reset     = 1'b1;
                out_ready = 1'b0;
                @(posedge clk); #1;
                reset = 1'b0;
                chk("midreset_idle", {30'd0, outs()}, {30'd0, pk(0,0,0,0,4'd0,10'(BASE_ADDR),16'h0)});
                q.delete();
                return;
            end

            if (stall_at >= 0 && out_valid && hs == stall_at && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                chk("stall_hold", {30'd0, outs()},
                    {30'd0, pk(1,1,0,0,4'd1,10'(BASE_ADDR + 1),16'h0101)});
            end

            if ((hs == ign_a || hs == ign_b) && out_valid) drain_start = 1'b1;

            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("extra_word", 64'(out_data), 64'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("word_data", 64'(out_data), 64'(e.data));
                    chk("word_last", 64'(out_last), 64'(e.last));
                    chk("word_addr", {50'd0, pe_addr, reg_addr}, {50'd0, e.pe, e.ra});
                end
                if (gap_chk && last_hs >= 0)
                    chk("word_gap", 64'(iter - last_hs), 64'(READ_LAT + 2));
                last_hs = iter;
                hs++;
            end

            if (done_cnt > 0 && iter >= done_iter + 4) begin
                finished = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end

        chk("drain_finished", {63'd0, finished}, 64'd1);
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("word_count", 64'(hs), 64'(TOTAL));
        chk("idle_after", {62'd0, busy, out_valid}, 64'd0);
        chk("queue_empty", 64'(q.size()), 64'd0);
        q.delete();
    endtask

    initial begin
        reset       = 1'b1;
        drain_start = 1'b0;
        out_ready   = 1'b0;

        //              rst   start rdy   busy,valid,done,last,pe,reg,data
        tbl[0]  = {1'b1, 1'b0, 1'b0, pk(0,0,0,0,4'd0,10'd0,16'h0)};
        tbl[1]  = {1'b1, 1'b0, 1'b0, pk(0,0,0,0,4'd0,10'd0,16'h0)};
        tbl[2]  = {1'b1, 1'b0, 1'b0, pk(0,0,0,0,4'd0,10'd0,16'h0)};
        tbl[3]  = {1'b0, 1'b0, 1'b1, pk(0,0,0,0,4'd0,10'd0,16'h0)};
        tbl[4]  = {1'b0, 1'b0, 1'b1, pk(0,0,0,0,4'd0,10'd0,16'h0)};
        tbl[5]  = {1'b1, 1'b1, 1'b0, pk(0,0,0,0,4'd0,10'd0,16'h0)};   // reset beats start
        tbl[6]  = {1'b0, 1'b0, 1'b0, pk(0,0,0,0,4'd0,10'd0,16'h0)};
        tbl[7]  = {1'b0, 1'b1, 1'b0, pk(1,0,0,0,4'd0,10'd0,16'h0)};   // ISSUE
        tbl[8]  = {1'b0, 1'b0, 1'b0, pk(1,0,0,0,4'd0,10'd0,16'h0)};   // WAIT
        tbl[9]  = {1'b0, 1'b0, 1'b0, pk(1,1,0,0,4'd0,10'd0,16'h0)};   // HOLD
        tbl[10] = {1'b0, 1'b0, 1'b0, pk(1,1,0,0,4'd0,10'd0,16'h0)};   // held
        tbl[11] = {1'b0, 1'b0, 1'b1, pk(1,0,0,0,4'd0,10'd1,16'h0)};   // accepted
        tbl[12] = {1'b1, 1'b0, 1'b0, pk(0,0,0,0,4'd0,10'd0,16'h0)};   // reset mid-drain

        for (int i = 0; i < 13; i++) begin
            reset       = tbl[i].rst;
            drain_start = tbl[i].start;
            out_ready   = tbl[i].rdy;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), {30'd0, outs()}, {30'd0, tbl[i].exp});
        end

        reset       = 1'b0;
        drain_start = 1'b0;
        out_ready   = 1'b0;
        @(posedge clk); #1;

        run_drain(-1, -1, -1, -1, 1'b1);   // full drain, throughput
        run_drain(17, -1, -1, -1, 1'b0);   // backpressure on 0x0101
        run_drain(-1, 10, 200, -1, 1'b0);  // ignored starts
        run_drain(-1, -1, -1, 40, 1'b0);   // reset while holding word 40
        run_drain(-1, -1, -1, -1, 1'b1);   // restart from pe 0 reg 0

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/result_drain.md
Name: result_drain

Overview:
- Downstream readback stage for the PE array top level.
- After a program finishes, walks every PE and a contiguous window of its register file through the array's PE_Addr/RegAddr/data readout port.
- Emits each 16-bit word on a valid/ready stream toward the host interface.
- Replaces manual host-side address poking with a single start pulse and a completion pulse.

Parameters:
- SIZE, 4: array edge; SIZE*SIZE PEs; PE address width is SIZE bits, matching the array.
- NUM_REGS, 16: registers read per PE (1..1024).
- BASE_ADDR, 0: first register address read in each PE; BASE_ADDR+NUM_REGS-1 must be ≤1023 (elaboration-time error otherwise).
- READ_LAT, 1: cycles from address change to valid rd_data (0..3).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- drain_start  in  1  one-cycle pulse; begins a drain when idle
- pe_addr  out  SIZE  drives array PE_Addr
- reg_addr  out  10  drives array RegAddr
- rd_data  in  16  array data readout
- out_data  out  16  stream payload
- out_valid  out  1  payload valid
- out_ready  in  1  consumer accepts when high with out_valid
- out_last  out  1  high with final word of a drain
- busy  out  1  high from the cycle after drain_start until done
- done  out  1  one-cycle pulse after final handshake

Behaviour:
- Reset (any cycle, including mid-drain): state IDLE next cycle.
  - pe_addr=0, reg_addr=BASE_ADDR.
  - out_data=0, out_valid=0, out_last=0, busy=0, done=0.
  - All counters cleared; partial drain discarded.
- FSM states: IDLE, ISSUE, WAIT, HOLD, DONE.
  - IDLE: drain_start=1 -> ISSUE; pe counter=0, reg counter=0, busy=1 next cycle.
  - ISSUE (1 cycle): pe_addr/reg_addr driven from counters (reg_addr = BASE_ADDR + reg counter). Next state is WAIT if READ_LAT>0, else HOLD.
  - WAIT: stays READ_LAT cycles, then captures rd_data into out_data and enters HOLD. With READ_LAT=0, capture happens at the end of ISSUE.
  - HOLD: out_valid=1; out_data and out_last are stable until handshake.
    - On out_valid&&out_ready: if last word -> DONE; otherwise advance counters -> ISSUE.
    - out_valid deasserts the cycle after handshake.
  - DONE (1 cycle): done=1, busy=0 -> IDLE.
- Address hold: pe_addr/reg_addr stay stable from ISSUE through HOLD.
- Ordering is PE-major: reg counter 0..NUM_REGS-1 within each PE, then pe 0..SIZE*SIZE-1. Total words = SIZE*SIZE*NUM_REGS (256 by default).
- Counter wrap: reg counter wraps to 0 and pe increments. out_last=1 only when pe=SIZE*SIZE-1 and reg=NUM_REGS-1.
- Throughput: one word per READ_LAT+2 cycles when out_ready is held high.
- drain_start while busy or in DONE: ignored, no effect on counters.
- drain_start coincident with reset: reset wins.
- out_ready while out_valid=0: ignored.

Optional Feature:
- Macro: DRAIN_CHECKSUM_EN.
- Defined:
  - A 16-bit running XOR of all captured words is kept; it is cleared on reset and on drain_start.
  - After the final data word's handshake, one extra HOLD word carries the XOR value, with out_last=1 on that word only. done follows its handshake.
  - Total words = SIZE*SIZE*NUM_REGS+1.
- Undefined: no checksum logic; out_last is on the final data word.

Test Plan:
- Reset behaviour: hold reset 3 cycles, then release -> all outputs 0, reg_addr=0, busy=0; out_valid stays 0 with no drain_start.
- Full drain: defaults, READ_LAT=1, memory model returns pe*256+reg, out_ready=1.
  - Expect 256 words 0x0000..0x000F, 0x0100..0x0F0F in order, 3 cycles apart.
  - out_last only on 0x0F0F; done pulse 1 cycle later; busy low after.
- Backpressure: out_ready=0 for 5 cycles while word 17 (0x0101) is presented -> out_valid, out_data=0x0101 and pe_addr=1, reg_addr=1 all held stable; after ready, the next word is 0x0102.
- Ignored start: drain_start pulsed at words 10 and 200 -> exactly 256 words, a single done pulse.
- Mid-drain reset: reset at word 40 while in HOLD -> IDLE next cycle with outputs 0; a new drain_start restarts at pe 0 reg 0 (first word 0x0000).
- DRAIN_CHECKSUM_EN: same data as full drain -> 257th word equals the XOR of all 256 words, out_last only on word 257, done after its handshake.
